// File: rtl/comparator_bist_pkg.sv
// Types and constants shared by the comparator BIST, built on cmp_defs.vh.
package comparator_bist_pkg;
`include "cmp_defs.vh"

   typedef enum logic [1:0] {
      S_IDLE   = `CMP_ST_IDLE,
      S_APPLY  = `CMP_ST_APPLY,
      S_CHECK  = `CMP_ST_CHECK,
      S_FINISH = `CMP_ST_FINISH
   } state_t;

   localparam int unsigned R_GT = `CMP_R_GT;
   localparam int unsigned R_EQ = `CMP_R_EQ;
   localparam int unsigned R_LT = `CMP_R_LT;

   localparam logic [7:0] LAST_IDX = 8'hFF;
endpackage

// File: rtl/cmp_defs.vh
// Shared encodings for the comparator BIST: FSM state codes and the bit
// positions of the one-hot comparator result.
`ifndef CMP_DEFS_VH
`define CMP_DEFS_VH

`define CMP_ST_IDLE   2'd0
`define CMP_ST_APPLY  2'd1
`define CMP_ST_CHECK  2'd2
`define CMP_ST_FINISH 2'd3

`define CMP_R_GT 2
`define CMP_R_EQ 1
`define CMP_R_LT 0

`endif

// File: rtl/cmp_golden.sv
// Reference 4-bit magnitude comparator producing the one-hot result the
// device under test is expected to return.
module cmp_golden
   import comparator_bist_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [2:0] RES
);

   always_comb begin
      RES = 3'b000;
      if (A > B)
         RES[R_GT] = 1'b1;
      else if (A == B)
         RES[R_EQ] = 1'b1;
      else
         RES[R_LT] = 1'b1;
   end

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive BIST for an external 4-bit comparator: sweeps all 256 {A,B}
// vectors, holds each for SETTLE cycles, then checks the returned result.
//
//   state  | meaning
//   IDLE   | waiting for START after reset
//   APPLY  | vector driven on A/B, settle counter running
//   CHECK  | sample R, compare against golden, advance index
//   FINISH | run done, DONE/PASS valid, START re-arms
module comparator_bist
   import comparator_bist_pkg::*;
#(
   parameter int unsigned SETTLE = 1
)
(
   input  logic       CLK,
   input  logic       nRST,
   input  logic       START,
   input  logic [2:0] R,
   output logic [3:0] A,
   output logic [3:0] B,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [8:0] ERR_CNT,
   output logic [7:0] FIRST_FAIL
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_idx;
   logic [3:0] r_settle;
   logic [8:0] r_err_cnt;
   logic [7:0] r_first_fail;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_start_run;
   logic       w_fail;
   logic [2:0] w_exp;
   logic [8:0] w_err_nxt;

   cmp_golden u_golden (
      .A   (r_idx[7:4]),
      .B   (r_idx[3:0]),
      .RES (w_exp)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_start_run = 1'b0;
      case (r_state)
         S_IDLE, S_FINISH: begin
            if (START) begin
               w_start_run = 1'b1;
               w_state_nxt = S_APPLY;
            end
         end
         S_APPLY: begin
            if (r_settle == 4'd0)
               w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            w_state_nxt = (r_idx == LAST_IDX) ? S_FINISH : S_APPLY;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Any R other than the exact golden code fails, non-one-hot included.
   assign w_fail    = (r_state == S_CHECK) && (R != w_exp);
   assign w_err_nxt = r_err_cnt + {8'd0, w_fail};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= S_IDLE;
         r_idx        <= 8'h00;
         r_settle     <= 4'd0;
         r_err_cnt    <= 9'd0;
         r_first_fail <= 8'h00;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_APPLY) || (w_state_nxt == S_CHECK);
         if (w_start_run) begin
            r_idx        <= 8'h00;
            r_settle     <= SETTLE_LD;
            r_err_cnt    <= 9'd0;
            r_first_fail <= 8'h00;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
         end else begin
            case (r_state)
               S_APPLY: begin
                  if (r_settle != 4'd0)
                     r_settle <= r_settle - 4'd1;
               end
               S_CHECK: begin
                  r_err_cnt <= w_err_nxt;
                  if (w_fail && (r_err_cnt == 9'd0))
                     r_first_fail <= r_idx;
                  if (r_idx == LAST_IDX) begin
                     r_done <= 1'b1;
                     r_pass <= (w_err_nxt == 9'd0);
                  end else begin
                     r_idx    <= r_idx + 8'd1;
                     r_settle <= SETTLE_LD;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign A          = r_idx[7:4];
   assign B          = r_idx[3:0];
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign PASS       = r_pass;
   assign ERR_CNT    = r_err_cnt;
   assign FIRST_FAIL = r_first_fail;

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench for comparator_bist: a behavioural comparator model
// (correct, faulty or randomly corrupted) answers the BIST's vectors.
module tb_comparator_bist;
   import comparator_bist_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       START;
   logic [2:0] mode;
   logic [2:0] ftbl [256];
   logic       sel;

   logic [2:0] r1, r3;
   logic [3:0] a1, b1, a3, b3;
   logic       busy1, done1, pass1, busy3, done3, pass3;
   logic [8:0] err1, err3;
   logic [7:0] ff1, ff3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   function automatic logic [2:0] golden(input logic [3:0] a, input logic [3:0] b);
      if (a > b) return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   // Modes: 0 good, 1 stuck 010, 2 GT/LT swapped, 3 stuck 000, 4 table, 5 stuck 111
   function automatic logic [2:0] rfun(input logic [2:0] m, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] t);
      logic [2:0] g;
      g = golden(a, b);
      case (m)
         3'd0: return g;
         3'd1: return 3'b010;
         3'd2: return {g[0], g[1], g[2]};
         3'd3: return 3'b000;
         3'd4: return t;
         default: return 3'b111;
      endcase
   endfunction

   assign r1 = rfun(mode, a1, b1, ftbl[{a1, b1}]);
   assign r3 = rfun(mode, a3, b3, ftbl[{a3, b3}]);

   comparator_bist #(.SETTLE(1)) dut1 (
      .CLK(CLK), .nRST(nRST), .START(START), .R(r1), .A(a1), .B(b1),
      .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FIRST_FAIL(ff1)
   );

   comparator_bist #(.SETTLE(3)) dut3 (
      .CLK(CLK), .nRST(nRST), .START(START), .R(r3), .A(a3), .B(b3),
      .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .FIRST_FAIL(ff3)
   );

   wire [7:0] idx_s  = sel ? {a3, b3} : {a1, b1};
   wire       busy_s = sel ? busy3 : busy1;
   wire       done_s = sel ? done3 : done1;
   wire       pass_s = sel ? pass3 : pass1;
   wire [8:0] err_s  = sel ? err3 : err1;
   wire [7:0] ff_s   = sel ? ff3 : ff1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected error count and first failing index from the whole sweep.
   task automatic model(input logic [2:0] m, output int e, output int f);
      logic [7:0] iv;
      e = 0;
      f = 0;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         if (rfun(m, iv[7:4], iv[3:0], ftbl[i]) != golden(iv[7:4], iv[3:0])) begin
            if (e == 0) f = i;
            e++;
         end
      end
   endtask

   task automatic fill_table();
      logic [7:0] iv;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         if ($urandom_range(0, 5) == 0) ftbl[i] = 3'($urandom_range(0, 7));
         else                           ftbl[i] = golden(iv[7:4], iv[3:0]);
      end
   endtask

   task automatic wait_both_idle();
      int n;
      n = 0;
      while ((busy1 || busy3) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 3000) check("idle_timeout", 32'(n), 32'd0);
   endtask

   // act_kind: 0 none, 1 re-pulse START at act_idx, 2 assert reset at act_idx
   task automatic run(input int act_idx, input int act_kind, output int cycles,
                      output bit aborted);
      bit fired;
      fired   = 1'b0;
      aborted = 1'b0;
      cycles  = 0;
      wait_both_idle();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      while (busy_s && cycles < 5000) begin
         if (act_kind == 2 && idx_s == act_idx[7:0]) begin
            nRST    = 1'b0;
            aborted = 1'b1;
            break;
         end
         cycles++;
         if (act_kind == 1 && !fired && idx_s == act_idx[7:0]) begin
            START = 1'b1;
            fired = 1'b1;
         end
         @(negedge CLK);
         START = 1'b0;
      end
      if (cycles >= 5000) check("run_timeout", 32'(cycles), 32'd0);
   endtask

   task automatic check_done(input string tag, input int exp_e, input int exp_f,
                             input int exp_cyc, input int cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_done"},   32'(done_s), 32'd1);
      check({tag, "_busy"},   32'(busy_s), 32'd0);
      check({tag, "_pass"},   32'(pass_s), (exp_e == 0) ? 32'd1 : 32'd0);
      check({tag, "_err"},    32'(err_s), 32'(exp_e));
      check({tag, "_first"},  32'(ff_s), 32'(exp_f));
      check({tag, "_ab"},     32'(idx_s), 32'hFF);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, e, f;
      bit ab;
      sel   = 1'b0;
      mode  = 3'd5;
      nRST  = 1'b0;
      START = 1'b1;
      for (int i = 0; i < 256; i++) ftbl[i] = 3'b000;

      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("rst_out1", {a1, b1, busy1, done1, pass1, err1, ff1}, 32'd0);
         check("rst_out3", {a3, b3, busy3, done3, pass3, err3, ff3}, 32'd0);
         check("rst_state", 32'(dut1.r_state), 32'(S_IDLE));
      end
      START = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      repeat (3) @(negedge CLK);
      check("post_rst_idle", 32'(busy1), 32'd0);

      mode = 3'd0;
      run(0, 0, cyc, ab);
      check_done("good", 0, 0, 512, cyc);

      mode = 3'd1;
      run(0, 0, cyc, ab);
      check_done("stuck010", 240, 8'h01, 512, cyc);

      mode = 3'd2;
      run(0, 0, cyc, ab);
      check_done("swap", 240, 8'h01, 512, cyc);

      mode = 3'd3;
      run(0, 0, cyc, ab);
      check_done("zero", 256, 8'h00, 512, cyc);

      mode = 3'd4;
      for (int k = 0; k < 3; k++) begin
         fill_table();
         model(mode, e, f);
         run(0, 0, cyc, ab);
         check_done("rand", e, f, 512, cyc);
      end

      fill_table();
      model(mode, e, f);
      run(50, 1, cyc, ab);
      check_done("restart50", e, f, 512, cyc);
      run(0, 0, cyc, ab);
      check_done("rerun", e, f, 512, cyc);

      fill_table();
      run(100, 2, cyc, ab);
      #1;
      check("abort_seen", 32'(ab), 32'd1);
      check("abort_out", {a1, b1, busy1, done1, pass1, err1, ff1}, 32'd0);
      check("abort_state", 32'(dut1.r_state), 32'(S_IDLE));
      @(negedge CLK);
      nRST = 1'b1;
      repeat (3) @(negedge CLK);
      check("abort_stay_idle", {busy1, done1, busy3, done3}, 32'd0);

      mode = 3'd0;
      run(0, 0, cyc, ab);
      check_done("after_abort", 0, 0, 512, cyc);

      sel = 1'b1;
      run(0, 0, cyc, ab);
      check_done("settle3", 0, 0, 1024, cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 The module SHALL have one parameter: SETTLE, default 1, number of clock cycles each vector is held before R is sampled (legal range 1..15).
REQ-002 The module SHALL have these ports:
- CLK  input  1  rising-edge system clock.
- nRST  input  1  asynchronous active-low reset.
- START  input  1  single-cycle run request.
- R  input  3  comparator result under test: R[2]=A>B, R[1]=A=B, R[0]=A<B.
- A  output  4  operand A driven to the comparator.
- B  output  4  operand B driven to the comparator.
- BUSY  output  1  run in progress.
- DONE  output  1  run complete; held until next run or reset.
- PASS  output  1  valid with DONE: 1 when ERR_CNT is 0.
- ERR_CNT  output  9  number of failing vectors, 0..256.
- FIRST_FAIL  output  8  {A,B} of the first failing vector; 8'h00 if none.

Function
REQ-003 The FSM SHALL have states IDLE, APPLY, CHECK and FINISH.
REQ-004 In IDLE or FINISH, START=1 SHALL clear ERR_CNT, FIRST_FAIL, DONE and PASS, set the 8-bit vector index {A,B} to 8'h00 and enter APPLY on the next edge.
REQ-005 START SHALL be ignored in APPLY and CHECK.
REQ-006 Vector order SHALL be A-major, B-minor: index 0..255, A=index[7:4], B=index[3:0]; A and B SHALL change only on the edge entering APPLY.
REQ-007 APPLY SHALL last exactly SETTLE cycles (4-bit down-counter), then enter CHECK.
REQ-008 CHECK SHALL last one cycle, sample R and compare it to the expected one-hot code for the current A, B.
REQ-009 A vector SHALL fail when R differs from expected, including any non-one-hot R (3'b000, 3'b011, 3'b111, ...).
REQ-010 On failure ERR_CNT SHALL increment by 1; if it was 0 before the increment, FIRST_FAIL SHALL be loaded with the index.
REQ-011 From CHECK with index 8'hFF the FSM SHALL enter FINISH; otherwise the index SHALL increment and the FSM SHALL re-enter APPLY.
REQ-012 In FINISH, DONE SHALL be 1 and PASS SHALL equal (ERR_CNT==0). A, B SHALL hold 4'hF, 4'hF.
REQ-013 BUSY SHALL be 1 exactly in APPLY and CHECK.
REQ-014 A run SHALL take 256*(SETTLE+1) cycles from the first APPLY cycle to the first FINISH cycle (512 at SETTLE=1).
REQ-015 ERR_CNT SHALL NOT wrap; 9 bits covers all 256 failures.
REQ-016 All outputs SHALL be registered. No combinational path SHALL run from R to any output.

Reset
REQ-017 nRST=0 SHALL asynchronously force state IDLE, A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, and clear the settle counter.
REQ-018 Reset asserted mid-run SHALL abandon the run. After release, only a new START SHALL begin a run, and it SHALL start from index 0.

Structure
REQ-019 The state encodings (IDLE=2'd0, APPLY=2'd1, CHECK=2'd2, FINISH=2'd3) and the R bit positions (GT=2, EQ=1, LT=0) SHALL live in a shared include file, cmp_defs.vh, used by this block and by the benches.
REQ-020 The expected result SHALL come from one combinational sub-module, cmp_golden (inputs: 4-bit A and B; output: 3-bit one-hot result).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: nRST low with START=1 and R=3'b111 -> all outputs 0 and state IDLE throughout.
- Correct comparator on R, START pulse -> BUSY for 512 cycles, then DONE=1, PASS=1, ERR_CNT=0, FIRST_FAIL=8'h00.
- R stuck at 3'b010 -> ERR_CNT=240, FIRST_FAIL=8'h01, PASS=0.
- GT/LT bits swapped -> ERR_CNT=240, FIRST_FAIL=8'h01; R forced to 3'b000 -> ERR_CNT=256, FIRST_FAIL=8'h00.
- START re-pulsed at vector 50 -> ignored and run length unchanged; START in FINISH -> clean second run with identical results.
- nRST pulsed at vector 100 -> immediate IDLE with counts cleared; a new START gives a full 512-cycle run, PASS=1; repeat with SETTLE=3 -> 1024 cycles.
